// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment encoder/decoder pair.
// Both ends of the link take their pattern table from here.
package seg7_pkg;

    localparam int SEG_W   = 7;
    localparam int DIGIT_W = 4;

    // Segment patterns, bit0=a .. bit6=g, lit segment = 1
    localparam logic [SEG_W-1:0] SEG7_PAT_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG7_PAT_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG7_PAT_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG7_PAT_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG7_PAT_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG7_PAT_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG7_PAT_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG7_PAT_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG7_PAT_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG7_PAT_9 = 7'h6F;

    typedef enum logic {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to BCD digit decoder.
// Exact match only; anything outside the ten digit patterns (blank included)
// reports hit=0.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0]   seg_in,
    output logic               hit,
    output logic [DIGIT_W-1:0] digit
);

    // Table lookup against the shared pattern constants
    always_comb begin
        hit   = 1'b1;
        digit = '0;
        case (seg_in)
            SEG7_PAT_0: digit = 4'd0;
            SEG7_PAT_1: digit = 4'd1;
            SEG7_PAT_2: digit = 4'd2;
            SEG7_PAT_3: digit = 4'd3;
            SEG7_PAT_4: digit = 4'd4;
            SEG7_PAT_5: digit = 4'd5;
            SEG7_PAT_6: digit = 4'd6;
            SEG7_PAT_7: digit = 4'd7;
            SEG7_PAT_8: digit = 4'd8;
            SEG7_PAT_9: digit = 4'd9;
            default:    hit   = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_stream_decoder.sv
// Segment-pattern stream to packed BCD word decoder.
// Collects DIGITS decoded digits (first digit in the top nibble) and offers
// the word on a valid/ready handshake. Rejected patterns pulse err and
// discard the partial word; flush discards the partial or held word.
// Optional: define SEG7_DEC_ERRCNT_EN to get a saturating reject counter on
// err_count (otherwise err_count is tied to zero).
module seg7_stream_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SEG_W-1:0]           seg_in,
    input  logic                       seg_valid,
    output logic                       seg_ready,
    input  logic                       flush,
    output logic [DIGIT_W*DIGITS-1:0]  bcd_out,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic                       err,
    output logic [7:0]                 err_count
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(DIGITS + 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   count;
    logic [W-1:0]       bcd;
    logic               hit;
    logic [DIGIT_W-1:0] digit;
    logic [W-1:0]       digit_ext;
    logic               take;
    logic               last;

    seg7_pattern_decode u_decode (
        .seg_in (seg_in),
        .hit    (hit),
        .digit  (digit)
    );

    // A flush cycle drops the presented pattern outright, so it never
    // counts as a transfer (no shift, no err).
    assign take = seg_valid && seg_ready && !flush;
    assign last = (count == CNT_W'(DIGITS - 1));

    // Zero-extended digit; shifting the whole register and OR-ing the digit
    // in keeps DIGITS=1 legal without a negative-width slice.
    always_comb begin
        digit_ext = '0;
        digit_ext[DIGIT_W-1:0] = digit;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= COLLECT;
        else     state <= state_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        seg_ready  = 1'b0;
        word_valid = 1'b0;
        case (state)
            COLLECT: begin
                seg_ready = 1'b1;
                if (take && hit && last) state_next = OUTPUT;
            end
            OUTPUT: begin
                word_valid = 1'b1;
                if (word_ready) state_next = COLLECT;
            end
            default: state_next = COLLECT;
        endcase
        if (flush) state_next = COLLECT;
    end

    // Shift register, digit counter and reject pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            bcd   <= '0;
            err   <= 1'b0;
        end else begin
            err <= take && !hit;
            if (flush) begin
                count <= '0;
                bcd   <= '0;
            end else if (take) begin
                if (hit) begin
                    bcd   <= (bcd << DIGIT_W) | digit_ext;
                    count <= last ? '0 : count + CNT_W'(1);
                end else begin
                    count <= '0;
                    bcd   <= '0;
                end
            end
        end
    end

    assign bcd_out = bcd;

`ifdef SEG7_DEC_ERRCNT_EN
    logic [7:0] err_cnt;

    // Saturating reject counter; advances on the same edge that raises err
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               err_cnt <= '0;
        else if (take && !hit && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
    end

    assign err_count = err_cnt;
`else
    assign err_count = '0;
`endif

endmodule
